data_bus_responder: RTL and testbench

- Responder end of the core's data-SRAM interface. Memory stage reads data_sram_rdata from this block.
- Captures one load/store request issued in Execute and runs it as a single-beat AXI transaction.
- Returns read data aligned to the Memory stage and raises a stall request to CTRL until the transaction completes.
- Sits between mycpu_core's data port and the AXI crossbar.

---
 rtl/data_bus_responder_if.sv | 50 +++++
 rtl/data_bus_responder.sv | 150 +++++++++++++++
 tb/tb_data_bus_responder.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_responder_if.sv
// Single-beat AXI AR/R/AW/W/B channel bundle between the data-port responder and the crossbar.
// master = responder (issues requests), slave = crossbar/memory side.
interface data_bus_responder_if #(
    parameter int ID_W = 4
);
    logic [ID_W-1:0] arid;
    logic            arvalid;
    logic [31:0]     araddr;
    logic [2:0]      arsize;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    logic [ID_W-1:0] awid;
    logic            awvalid;
    logic [31:0]     awaddr;
    logic [2:0]      awsize;
    logic            awready;

    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wvalid;
    logic            wlast;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output arid, arvalid, araddr, arsize, rready,
        output awid, awvalid, awaddr, awsize,
        output wdata, wstrb, wvalid, wlast, bready,
        input  arready, rid, rdata, rresp, rvalid,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  arid, arvalid, araddr, arsize, rready,
        input  awid, awvalid, awaddr, awsize,
        input  wdata, wstrb, wvalid, wlast, bready,
        output arready, rid, rdata, rresp, rvalid,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/data_bus_responder.sv
// Runs one captured data-SRAM load/store as a single-beat AXI transaction; min load stall is 3 cycles.
// Backpressure: every AXI valid holds stable until its ready, and stallreq holds the pipeline meanwhile.
module data_bus_responder #(
    parameter int ID_W    = 4,
    parameter int DATA_ID = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq,
    input  logic        pipe_hold,
    data_bus_responder_if.master axi
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [ID_W-1:0] AXI_ID = ID_W'(DATA_ID);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wen_q, wen_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] rdata_q, rdata_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;

    logic ar_vld, r_rdy, aw_vld, w_vld, w_last, b_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wen_q     <= '0;
            size_q    <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wen_q     <= wen_d;
            size_q    <= size_d;
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wen_d     = wen_q;
        size_d    = size_q;
        rdata_d   = rdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        stallreq  = 1'b1;
        ar_vld    = 1'b0;
        r_rdy     = 1'b0;
        aw_vld    = 1'b0;
        w_vld     = 1'b0;
        w_last    = 1'b0;
        b_rdy     = 1'b0;

        case (state_q)
            IDLE: begin
                stallreq = data_sram_en;
                if (data_sram_en) begin
                    addr_d    = data_sram_addr;
                    wdata_d   = data_sram_wdata;
                    wen_d     = data_sram_wen;
                    size_d    = data_sram_size;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = (data_sram_wen == 4'd0) ? RD_ADDR : WR_REQ;
                end
            end
            RD_ADDR: begin
                ar_vld = 1'b1;
                if (axi.arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                r_rdy = 1'b1;
                if (axi.rvalid) begin
                    rdata_d = axi.rdata;
                    state_d = DONE;
                end
            end
            WR_REQ: begin
                // Each channel drops its valid once its own handshake is recorded.
                aw_vld    = !aw_done_q;
                w_vld     = !w_done_q;
                w_last    = 1'b1;
                aw_done_d = aw_done_q | (aw_vld & axi.awready);
                w_done_d  = w_done_q | (w_vld & axi.wready);
                if (aw_done_d && w_done_d) state_d = WR_RESP;
            end
            WR_RESP: begin
                b_rdy = 1'b1;
                if (axi.bvalid) state_d = DONE;
            end
            DONE: begin
                // Requests still presented here belong to the finished transaction.
                stallreq = 1'b0;
                if (!pipe_hold) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_sram_rdata = rdata_q;

    assign axi.arid    = AXI_ID;
    assign axi.arvalid = ar_vld;
    assign axi.araddr  = addr_q;
    assign axi.arsize  = {1'b0, size_q};
    assign axi.rready  = r_rdy;

    assign axi.awid    = AXI_ID;
    assign axi.awvalid = aw_vld;
    assign axi.awaddr  = addr_q;
    assign axi.awsize  = {1'b0, size_q};

    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wen_q;
    assign axi.wvalid  = w_vld;
    assign axi.wlast   = w_last;
    assign axi.bready  = b_rdy;

    // Response IDs and error codes carry no information for the core.
    logic unused_resp;
    assign unused_resp = ^{axi.rid, axi.rresp, axi.bid, axi.bresp};
endmodule

// File: tb/tb_data_bus_responder.sv
// Directed stimulus with a queue scoreboard: expected AXI beats and load results are queued at issue
// and a negedge monitor checks them against handshakes and stall release.
module tb_data_bus_responder;
    logic        clk;
    logic        rst;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq;
    logic        pipe_hold;

    data_bus_responder_if #(.ID_W(4)) bus ();

    data_bus_responder #(.ID_W(4), .DATA_ID(1)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_size  (data_sram_size),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .stallreq        (stallreq),
        .pipe_hold       (pipe_hold),
        .axi             (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
    } addr_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
    } w_exp_t;

    addr_exp_t   exp_ar[$];
    addr_exp_t   exp_aw[$];
    w_exp_t      exp_w[$];
    logic [31:0] exp_rd[$];

    int checks;
    int failures;
    int nst;
    bit prev_stall;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size);
        data_sram_en    = 1'b1;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
        data_sram_size  = size;
    endtask

    function automatic addr_exp_t mk_a(input logic [31:0] addr, input logic [2:0] size);
        addr_exp_t e;
        e.addr = addr;
        e.size = size;
        return e;
    endfunction

    function automatic w_exp_t mk_w(input logic [31:0] data, input logic [3:0] strb);
        w_exp_t e;
        e.data = data;
        e.strb = strb;
        return e;
    endfunction

    // Scoreboard monitor
    initial begin
        addr_exp_t a;
        w_exp_t    w;
        logic [31:0] r;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (bus.arvalid && bus.arready) begin
                    if (exp_ar.size() == 0) chk("ar_expected", 32'(exp_ar.size()), 32'd1);
                    else begin
                        a = exp_ar.pop_front();
                        chk("ar_addr", bus.araddr, a.addr);
                        chk("ar_size", 32'(bus.arsize), 32'(a.size));
                        chk("ar_id", 32'(bus.arid), 32'd1);
                    end
                end
                if (bus.awvalid && bus.awready) begin
                    if (exp_aw.size() == 0) chk("aw_expected", 32'(exp_aw.size()), 32'd1);
                    else begin
                        a = exp_aw.pop_front();
                        chk("aw_addr", bus.awaddr, a.addr);
                        chk("aw_size", 32'(bus.awsize), 32'(a.size));
                        chk("aw_id", 32'(bus.awid), 32'd1);
                    end
                end
                if (bus.wvalid && bus.wready) begin
                    if (exp_w.size() == 0) chk("w_expected", 32'(exp_w.size()), 32'd1);
                    else begin
                        w = exp_w.pop_front();
                        chk("w_data", bus.wdata, w.data);
                        chk("w_strb", 32'(bus.wstrb), 32'(w.strb));
                        chk("w_last", 32'(bus.wlast), 32'd1);
                    end
                end
                if (prev_stall && !stallreq) begin
                    if (exp_rd.size() == 0) chk("rd_expected", 32'(exp_rd.size()), 32'd1);
                    else begin
                        r = exp_rd.pop_front();
                        chk("rdata_at_done", data_sram_rdata, r);
                    end
                end
                prev_stall = stallreq;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        data_sram_en = 1'b0; data_sram_wen = '0; data_sram_size = '0;
        data_sram_addr = '0; data_sram_wdata = '0; pipe_hold = 1'b0;
        bus.arready = 1'b0; bus.rid = 4'd1; bus.rdata = '0; bus.rresp = 2'd0; bus.rvalid = 1'b0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bid = 4'd1; bus.bresp = 2'd0; bus.bvalid = 1'b0;
        checks = 0; failures = 0;

        // Reset state
        tick(); tick(); #1;
        chk("reset_valids", 32'({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}), 32'd0);
        chk("reset_stall", 32'(stallreq), 32'd0);
        chk("reset_rdata", data_sram_rdata, 32'd0);
        chk("reset_araddr", bus.araddr, 32'd0);
        rst = 1'b0;

        // Load, zero wait
        tick(); req(4'd0, 32'h1000_0004, 32'd0, 2'd2); bus.arready = 1'b1;
        exp_ar.push_back(mk_a(32'h1000_0004, 3'd2)); exp_rd.push_back(32'hDEAD_BEEF);
        #1 nst = int'(stallreq);
        tick(); data_sram_en = 1'b0; #1;
        chk("t1_arvalid", 32'(bus.arvalid), 32'd1); nst += int'(stallreq);
        tick(); bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_BEEF; #1;
        chk("t1_rready", 32'(bus.rready), 32'd1); nst += int'(stallreq);
        tick(); bus.rvalid = 1'b0; #1; nst += int'(stallreq);
        tick(); #1; nst += int'(stallreq);
        chk("t1_stall_cycles", 32'(nst), 32'd3);

        // Store, W before AW
        tick(); req(4'b0011, 32'h1000_0008, 32'h0000_ABCD, 2'd1);
        exp_aw.push_back(mk_a(32'h1000_0008, 3'd1)); exp_w.push_back(mk_w(32'h0000_ABCD, 4'b0011));
        exp_rd.push_back(32'hDEAD_BEEF);
        #1 nst = int'(stallreq);
        tick(); data_sram_en = 1'b0; bus.wready = 1'b1; #1;
        chk("t2_awvalid_c1", 32'(bus.awvalid), 32'd1);
        chk("t2_wvalid_c1", 32'(bus.wvalid), 32'd1);
        nst += int'(stallreq);
        tick(); bus.wready = 1'b0; #1;
        chk("t2_wvalid_dropped", 32'(bus.wvalid), 32'd0);
        chk("t2_awvalid_held", 32'(bus.awvalid), 32'd1); nst += int'(stallreq);
        tick(); bus.awready = 1'b1; #1;
        chk("t2_awvalid_c3", 32'(bus.awvalid), 32'd1); nst += int'(stallreq);
        tick(); bus.awready = 1'b0; #1;
        chk("t2_bready", 32'(bus.bready), 32'd1);
        chk("t2_stall_before_b", 32'(stallreq), 32'd1); nst += int'(stallreq);
        tick(); bus.bvalid = 1'b1; #1; nst += int'(stallreq);
        tick(); bus.bvalid = 1'b0; #1; nst += int'(stallreq);
        chk("t2_stall_cycles", 32'(nst), 32'd6);

        // AR backpressure, then pipe_hold in DONE
        tick(); req(4'd0, 32'h2000_0010, 32'd0, 2'd1);
        exp_ar.push_back(mk_a(32'h2000_0010, 3'd1)); exp_rd.push_back(32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            tick(); data_sram_en = 1'b0; #1;
            chk("t3_arvalid_held", 32'(bus.arvalid), 32'd1);
            chk("t3_araddr_stable", bus.araddr, 32'h2000_0010);
            chk("t3_rready_low", 32'(bus.rready), 32'd0);
        end
        tick(); bus.arready = 1'b1; #1;
        chk("t3_arvalid_hs", 32'(bus.arvalid), 32'd1);
        tick(); bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h1234_5678; #1;
        chk("t3_rready", 32'(bus.rready), 32'd1);
        tick(); bus.rvalid = 1'b0; req(4'd0, 32'h3000_0000, 32'd0, 2'd2); pipe_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            #1;
            chk("t4_hold_stall", 32'(stallreq), 32'd0);
            chk("t4_hold_no_ar", 32'(bus.arvalid), 32'd0);
            chk("t4_hold_rdata", data_sram_rdata, 32'h1234_5678);
        end
        tick(); pipe_hold = 1'b0; #1;
        chk("t4_last_done_stall", 32'(stallreq), 32'd0);
        tick(); #1;
        exp_ar.push_back(mk_a(32'h3000_0000, 3'd2)); exp_rd.push_back(32'hCAFE_F00D);
        chk("t4_idle_accept", 32'(stallreq), 32'd1);
        chk("t4_idle_no_ar", 32'(bus.arvalid), 32'd0);
        tick(); data_sram_en = 1'b0; bus.arready = 1'b1; #1;
        chk("t4_arvalid", 32'(bus.arvalid), 32'd1);
        tick(); bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'hCAFE_F00D;
        tick(); bus.rvalid = 1'b0;
        tick();

        // Back-to-back load then store with en held high
        tick(); req(4'd0, 32'h4000_0000, 32'd0, 2'd2);
        exp_ar.push_back(mk_a(32'h4000_0000, 3'd2)); exp_rd.push_back(32'h0BAD_F00D);
        tick(); bus.arready = 1'b1; #1;
        chk("t6_arvalid", 32'(bus.arvalid), 32'd1);
        tick(); bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h0BAD_F00D;
        req(4'hF, 32'h4000_0004, 32'h55AA_55AA, 2'd2);
        tick(); bus.rvalid = 1'b0; #1;
        chk("t6_done_no_accept", 32'(stallreq), 32'd0);
        chk("t6_done_no_aw", 32'(bus.awvalid), 32'd0);
        tick(); #1;
        exp_aw.push_back(mk_a(32'h4000_0004, 3'd2)); exp_w.push_back(mk_w(32'h55AA_55AA, 4'hF));
        exp_rd.push_back(32'h0BAD_F00D);
        chk("t6_idle_accept", 32'(stallreq), 32'd1);
        chk("t6_idle_no_aw", 32'(bus.awvalid), 32'd0);
        tick(); data_sram_en = 1'b0; bus.awready = 1'b1; bus.wready = 1'b1; #1;
        chk("t6_aw_w_same_cycle", 32'({bus.awvalid, bus.wvalid}), 32'd3);
        tick(); bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b1; #1;
        chk("t6_bready", 32'(bus.bready), 32'd1);
        tick(); bus.bvalid = 1'b0; #1;
        chk("t6_done_stall", 32'(stallreq), 32'd0);
        tick();

        // Reset in WR_RESP
        tick(); req(4'b1000, 32'h5000_0000, 32'h1100_0000, 2'd0);
        exp_aw.push_back(mk_a(32'h5000_0000, 3'd0)); exp_w.push_back(mk_w(32'h1100_0000, 4'b1000));
        tick(); data_sram_en = 1'b0; bus.awready = 1'b1; bus.wready = 1'b1;
        tick(); bus.awready = 1'b0; bus.wready = 1'b0; #1;
        chk("t5_in_wr_resp", 32'(bus.bready), 32'd1);
        rst = 1'b1;
        tick(); #1;
        chk("t5_valids", 32'({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}), 32'd0);
        chk("t5_stall", 32'(stallreq), 32'd0);
        chk("t5_rdata", data_sram_rdata, 32'd0);
        chk("t5_wstrb", 32'(bus.wstrb), 32'd0);
        chk("t5_awaddr", bus.awaddr, 32'd0);
        rst = 1'b0;
        tick(); tick();

        chk("ar_queue_drained", 32'(exp_ar.size()), 32'd0);
        chk("aw_queue_drained", 32'(exp_aw.size()), 32'd0);
        chk("w_queue_drained", 32'(exp_w.size()), 32'd0);
        chk("rd_queue_drained", 32'(exp_rd.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
